intn_to_fp16_stream: RTL and testbench
======================================

Name: intn_to_fp16_stream

Overview:
Multi-lane, pipelined converter from N-bit integers to IEEE-754 binary16 with a valid/ready stream interface. It is the parametrised successor of the single-lane combinational int-to-fp16 converter in the fp-mul-int accelerator datapath.
- Generalised: INT_WIDTH 1..16, signed or unsigned mode, NUM_LANES lanes per beat.
- New behaviour: correct two's-complement magnitude, round-to-nearest-even for magnitudes wider than 11 bits, and overflow/inexact flags.
- Sits between the integer operand streamer and the fp16 multiplier array.

Parameters:
- INT_WIDTH, 4: integer width per lane. Legal range 1..16; anything else is an elaboration error.
- NUM_LANES, 4: lanes per beat. Legal range 1..16.
- SIGNED, 1: 1 = two's-complement input, 0 = unsigned input.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: synchronous, active-high reset.
- in_valid_i, input, 1: input beat valid.
- in_ready_o, output, 1: converter accepts a beat.
- in_data_i, input, NUM_LANES*INT_WIDTH: lane k occupies bits [k*INT_WIDTH +: INT_WIDTH].
- out_valid_o, output, 1: output beat valid.
- out_ready_i, input, 1: downstream accepts a beat.
- out_data_o, output, NUM_LANES*16: lane k occupies bits [k*16 +: 16].
- out_ovf_o, output, NUM_LANES: per-lane result overflowed the fp16 range.
- out_inexact_o, output, NUM_LANES: per-lane result was rounded.

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: s1_valid, s2_valid, out_valid_o = 0; out_data_o, out_ovf_o, out_inexact_o = 0. A reset mid-stream discards all in-flight beats; nothing stale appears after reset.
- Pipeline: 2 register stages. Latency is 2 cycles from the accepting edge to out_valid_o. Throughput is 1 beat/cycle while out_ready_i = 1.
- Stage 1 (per lane):
  - Sign: sign = SIGNED ? msb : 0.
  - Magnitude: mag = sign ? -x : x, computed as an INT_WIDTH-bit unsigned value. The signed minimum -2^(W-1) therefore yields magnitude 2^(W-1).
  - Leading-one detect: p = index of the most significant 1 in mag; zero flag set when mag = 0.
  - Register sign, mag, p, zero.
- Stage 2 (per lane): normalise, round, pack.
  - zero: result 0x0000 (never 0x8000), flags 0.
  - Exponent: exp = 15 + p.
  - Mantissa: the bits below the leading one, left-aligned into 10 bits.
  - If p > 10, drop p-10 LSBs and apply round-to-nearest-even:
    - guard = bit p-11; sticky = OR of bits below it; lsb = kept mantissa LSB.
    - Round up iff guard & (sticky | lsb).
    - inexact = guard | sticky.
  - Mantissa carry-out: mantissa becomes 0 and exp increments.
  - exp = 31 after rounding: result = {sign, 0x7C00} (infinity) and ovf = 1. Only reachable when SIGNED = 0, INT_WIDTH = 16 and input >= 65520.
  - Output: {sign, exp[4:0], man[9:0]}.
- Handshake:
  - s2_en = !s2_valid | out_ready_i.
  - s1_en = !s1_valid | s2_en.
  - in_ready_o = s1_en. This is a combinational path from out_ready_i, which is acceptable.
  - A beat transfers when valid & ready. Each stage holds its data while stalled.
  - out_valid_o never drops without out_ready_i; out_data_o is stable while out_valid_o & !out_ready_i.
  - At most 2 beats are buffered. In-order delivery; no loss or duplication.
  - Simultaneous accept and emit in the same cycle is legal and keeps the pipe full.
- INT_WIDTH = 1:
  - SIGNED = 1: values {0, -1} map to {0x0000, 0xBC00}.
  - SIGNED = 0: values {0, 1} map to {0x0000, 0x3C00}.

Optional Feature:
INTN_FP16_SATURATE_EN
- Defined: overflow produces {sign, 0x7BFF} (max finite, ±65504); ovf is still asserted.
- Undefined: overflow produces ±infinity as specified above.

Decomposition:
- Package intn_fp16_pkg:
  - FP16_BIAS = 15, FP16_EXP_W = 5, FP16_MAN_W = 10.
  - FP16_POS_INF = 16'h7C00, FP16_MAX = 16'h7BFF.
  - typedef fp16_t: packed struct {sign, exp, man}.
  - typedef lane_s1_t: stage-1 register bundle.
- Sub-module intn_fp16_lane: combinational stage-1 and stage-2 functions for one lane, instantiated NUM_LANES times.
- The top level owns the valid/ready control and all pipeline registers.

Test Plan:
- W=4, signed, 4 lanes, out_ready_i = 1: input {0, 1, -1, -8} -> {0x0000, 0x3C00, 0xBC00, 0xC800}, flags 0, out_valid_o exactly 2 cycles after accept.
- W=16, unsigned: inputs 2049 -> 0x6800 (tie to even) and 2051 -> 0x6802; inexact = 1, ovf = 0 for both.
- W=16, unsigned, input 65535:
  - Without the macro -> 0x7C00, ovf = 1.
  - With INTN_FP16_SATURATE_EN -> 0x7BFF, ovf = 1.
- W=16, signed: -32768 -> 0xF800 exact; 32767 -> 0x7800 with inexact = 1.
- Backpressure: stream 6 beats with out_ready_i low for 5 cycles mid-stream -> in_ready_o drops after 2 beats are buffered; all 6 outputs emerge in order with no duplicates and data stable while stalled.
- rst_i high for 1 cycle with both stages valid -> out_valid_o = 0 and outputs 0 the next cycle; the first post-reset beat emerges 2 cycles after its accept.

Source files
------------

// File: rtl/intn_fp16_pkg.sv
// Shared fp16 constants and pipeline bundle types for the int-to-fp16 stream converter.
package intn_fp16_pkg;

    localparam int FP16_BIAS  = 15;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    localparam logic [15:0] FP16_POS_INF = 16'h7C00;
    localparam logic [15:0] FP16_MAX     = 16'h7BFF;

    // Widest integer a lane can carry; narrower lanes zero-extend their magnitude.
    localparam int LANE_MAX_W = 16;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_MAN_W-1:0] man;
    } fp16_t;

    typedef struct packed {
        logic                  sign;
        logic [LANE_MAX_W-1:0] mag;
        logic [3:0]            pos;
        logic                  zero;
    } lane_s1_t;

endpackage

// File: rtl/intn_fp16_lane.sv
// One conversion lane: stage-1 sign/magnitude/leading-one and stage-2 normalise/round/pack.
// INTN_FP16_SATURATE_EN clamps overflow to max finite instead of infinity.
module intn_fp16_lane
    import intn_fp16_pkg::*;
#(
    parameter int INT_WIDTH = 4,
    parameter int SIGNED    = 1
) (
    input  logic [INT_WIDTH-1:0] int_i,
    output lane_s1_t             s1_o,
    input  lane_s1_t             s1_i,
    output fp16_t                result_o,
    output logic                 ovf_o,
    output logic                 inexact_o
);

    logic [INT_WIDTH-1:0]  magNarrow;
    logic [LANE_MAX_W-1:0] magWide;
    logic                  signBit;
    logic [3:0]            posVal;

    always_comb begin
        signBit   = (SIGNED != 0) ? int_i[INT_WIDTH-1] : 1'b0;
        magNarrow = signBit ? -int_i : int_i;
        magWide   = '0;
        magWide[INT_WIDTH-1:0] = magNarrow;
        posVal = '0;
        for (int i = 0; i < LANE_MAX_W; i++) begin
            if (magWide[i]) posVal = 4'(i);
        end
        s1_o.sign = signBit;
        s1_o.mag  = magWide;
        s1_o.pos  = posVal;
        s1_o.zero = ~|magWide;
    end

    logic [15:0] normMag;
    logic        guardBit;
    logic        stickyBit;
    logic        roundUp;
    logic [10:0] manRound;
    logic [5:0]  expWide;

    // Leading one lands on bit 15; bits [14:5] are the mantissa, [4] guard, [3:0] sticky.
    always_comb begin
        normMag   = s1_i.mag << (4'd15 - s1_i.pos);
        guardBit  = normMag[4];
        stickyBit = |normMag[3:0];
        roundUp   = guardBit & (stickyBit | normMag[5]);
        manRound  = {1'b0, normMag[14:5]} + {10'd0, roundUp};
        expWide   = 6'(FP16_BIAS) + {2'b00, s1_i.pos} + {5'd0, manRound[10]};
        result_o  = fp16_t'({s1_i.sign, expWide[4:0], manRound[9:0]});
        ovf_o     = 1'b0;
        inexact_o = guardBit | stickyBit;
        if (expWide == 6'd31) begin
            ovf_o = 1'b1;
`ifdef INTN_FP16_SATURATE_EN
            result_o = fp16_t'({s1_i.sign, FP16_MAX[14:0]});
`else
            result_o = fp16_t'({s1_i.sign, FP16_POS_INF[14:0]});
`endif
        end
        if (s1_i.zero) begin
            result_o  = '0;
            ovf_o     = 1'b0;
            inexact_o = 1'b0;
        end
    end

endmodule

// File: rtl/intn_to_fp16_stream.sv
// Multi-lane two-stage valid/ready converter from INT_WIDTH-bit integers to fp16.
// Define INTN_FP16_SATURATE_EN to saturate overflow to +/-65504 instead of infinity.
module intn_to_fp16_stream
    import intn_fp16_pkg::*;
#(
    parameter int INT_WIDTH = 4,
    parameter int NUM_LANES = 4,
    parameter int SIGNED    = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NUM_LANES*INT_WIDTH-1:0] in_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NUM_LANES*16-1:0]        out_data_o,
    output logic [NUM_LANES-1:0]           out_ovf_o,
    output logic [NUM_LANES-1:0]           out_inexact_o
);

    if (INT_WIDTH < 1 || INT_WIDTH > LANE_MAX_W) begin : g_badWidth
        $error("intn_to_fp16_stream: INT_WIDTH must be 1..16");
    end
    if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_badLanes
        $error("intn_to_fp16_stream: NUM_LANES must be 1..16");
    end

    lane_s1_t s1Lane_d [NUM_LANES];
    lane_s1_t s1Lane_q [NUM_LANES];
    fp16_t    resLane  [NUM_LANES];

    logic [NUM_LANES*16-1:0] outData_d;
    logic [NUM_LANES-1:0]    outOvf_d;
    logic [NUM_LANES-1:0]    outInexact_d;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        intn_fp16_lane #(
            .INT_WIDTH (INT_WIDTH),
            .SIGNED    (SIGNED)
        ) u_lane (
            .int_i     (in_data_i[k*INT_WIDTH +: INT_WIDTH]),
            .s1_o      (s1Lane_d[k]),
            .s1_i      (s1Lane_q[k]),
            .result_o  (resLane[k]),
            .ovf_o     (outOvf_d[k]),
            .inexact_o (outInexact_d[k])
        );
        assign outData_d[k*16 +: 16] = resLane[k];
    end

    logic s1Valid_q;
    logic s2Valid_q;
    logic s2En;
    logic s1En;

    logic [NUM_LANES*16-1:0] outData_q;
    logic [NUM_LANES-1:0]    outOvf_q;
    logic [NUM_LANES-1:0]    outInexact_q;

    assign s2En       = !s2Valid_q || out_ready_i;
    assign s1En       = !s1Valid_q || s2En;
    assign in_ready_o = s1En;

    // Each stage advances only when the stage ahead of it frees up, otherwise it holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1Valid_q    <= 1'b0;
            s2Valid_q    <= 1'b0;
            outData_q    <= '0;
            outOvf_q     <= '0;
            outInexact_q <= '0;
            for (int k = 0; k < NUM_LANES; k++) s1Lane_q[k] <= '0;
        end else begin
            if (s1En) begin
                s1Valid_q <= in_valid_i;
                if (in_valid_i) s1Lane_q <= s1Lane_d;
            end
            if (s2En) begin
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    outData_q    <= outData_d;
                    outOvf_q     <= outOvf_d;
                    outInexact_q <= outInexact_d;
                end
            end
        end
    end

    assign out_valid_o   = s2Valid_q;
    assign out_data_o    = outData_q;
    assign out_ovf_o     = outOvf_q;
    assign out_inexact_o = outInexact_q;

endmodule

// File: tb/tb_intn_to_fp16_stream.sv
// Bench for intn_to_fp16_stream: three configurations driven in lockstep against an arithmetic reference.
// Honours INTN_FP16_SATURATE_EN for the expected overflow result.
module tb_intn_to_fp16_stream;

`ifdef INTN_FP16_SATURATE_EN
    localparam logic [15:0] OVF_RESULT = 16'h7BFF;
`else
    localparam logic [15:0] OVF_RESULT = 16'h7C00;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        outReady;
    logic [15:0] inA;
    logic [31:0] inB, inC;
    logic        readyA, readyB, readyC;
    logic        validA, validB, validC;
    logic [63:0] outA;
    logic [31:0] outB, outC;
    logic [3:0]  ovfA, inxA;
    logic [1:0]  ovfB, inxB, ovfC, inxC;

    int totalChecks = 0;
    int badChecks   = 0;

    always #5 clock = ~clock;

    intn_to_fp16_stream #(.INT_WIDTH(4), .NUM_LANES(4), .SIGNED(1)) dutA (
        .clk_i(clock), .rst_i(reset), .in_valid_i(inValid), .in_ready_o(readyA),
        .in_data_i(inA), .out_valid_o(validA), .out_ready_i(outReady),
        .out_data_o(outA), .out_ovf_o(ovfA), .out_inexact_o(inxA));

    intn_to_fp16_stream #(.INT_WIDTH(16), .NUM_LANES(2), .SIGNED(0)) dutB (
        .clk_i(clock), .rst_i(reset), .in_valid_i(inValid), .in_ready_o(readyB),
        .in_data_i(inB), .out_valid_o(validB), .out_ready_i(outReady),
        .out_data_o(outB), .out_ovf_o(ovfB), .out_inexact_o(inxB));

    intn_to_fp16_stream #(.INT_WIDTH(16), .NUM_LANES(2), .SIGNED(1)) dutC (
        .clk_i(clock), .rst_i(reset), .in_valid_i(inValid), .in_ready_o(readyC),
        .in_data_i(inC), .out_valid_o(validC), .out_ready_i(outReady),
        .out_data_o(outC), .out_ovf_o(ovfC), .out_inexact_o(inxC));

    typedef struct {
        logic [63:0] data;
        logic [3:0]  ovf;
        logic [3:0]  inx;
    } beat_t;

    beat_t qA[$], qB[$], qC[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: exact integer value -> {ovf, inexact, fp16} by plain arithmetic with RNE.
    function automatic logic [17:0] refLane(input int v);
        int m, e, q, rem, half, sh;
        logic s, ovf, inx;
        logic [15:0] r;
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 18'd0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        inx = 1'b0;
        if (e <= 10) begin
            q = m << (10 - e);
        end else begin
            sh   = e - 10;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            inx = (rem != 0);
        end
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        ovf = (e + 15 >= 31);
        if (ovf) r = {s, OVF_RESULT[14:0]};
        else     r = {s, 5'(e + 15), 10'(q - 1024)};
        return {ovf, inx, r};
    endfunction

    function automatic beat_t modelA(input logic [15:0] raw);
        beat_t b;
        logic [17:0] r;
        int v;
        b.data = '0; b.ovf = '0; b.inx = '0;
        for (int k = 0; k < 4; k++) begin
            v = int'(raw[k*4 +: 4]);
            if (v >= 8) v = v - 16;
            r = refLane(v);
            b.data[k*16 +: 16] = r[15:0];
            b.inx[k] = r[16];
            b.ovf[k] = r[17];
        end
        return b;
    endfunction

    function automatic beat_t modelW16(input logic [31:0] raw, input bit signedMode);
        beat_t b;
        logic [17:0] r;
        int v;
        b.data = '0; b.ovf = '0; b.inx = '0;
        for (int k = 0; k < 2; k++) begin
            v = int'(raw[k*16 +: 16]);
            if (signedMode && v >= 32768) v = v - 65536;
            r = refLane(v);
            b.data[k*16 +: 16] = r[15:0];
            b.inx[k] = r[16];
            b.ovf[k] = r[17];
        end
        return b;
    endfunction

    function automatic logic [15:0] randLane16();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'hFFE0 | 16'($urandom_range(0, 31));
            2:       return 16'h8000 ^ 16'($urandom_range(0, 31));
            default: return 16'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic randBeat();
        inA = 16'($urandom);
        inB = {randLane16(), randLane16()};
        inC = {randLane16(), randLane16()};
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one beat and hold it until the handshake completes.
    task automatic applyStimulus(input logic [15:0] a, input logic [31:0] b, input logic [31:0] c);
        bit accepted;
        inA = a; inB = b; inC = c;
        inValid  = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clock);
            if (readyA) accepted = 1'b1;
            tick();
        end
        if (!accepted) checkOutput("acceptTimeout", readyA, 1);
        inValid = 1'b0;
    endtask

    logic        stallSeen = 1'b0;
    logic [63:0] heldA;
    logic [31:0] heldB, heldC;
    beat_t       eA, eB, eC;

    // Scoreboard: record accepted beats, retire delivered beats, and watch stalled outputs.
    always @(negedge clock) begin
        if (reset) begin
            qA.delete(); qB.delete(); qC.delete();
            stallSeen = 1'b0;
        end else begin
            if (stallSeen) begin
                checkOutput("stallValid", validA, 1);
                checkOutput("stallDataA", outA, heldA);
                checkOutput("stallDataB", outB, heldB);
                checkOutput("stallDataC", outC, heldC);
            end
            if (validA && outReady) begin
                if (qA.size() == 0) begin
                    checkOutput("unexpectedBeat", validA, 0);
                end else begin
                    eA = qA.pop_front();
                    eB = qB.pop_front();
                    eC = qC.pop_front();
                    checkOutput("dataA", outA, eA.data);
                    checkOutput("flagsA", {ovfA, inxA}, {eA.ovf, eA.inx});
                    checkOutput("dataB", outB, eB.data);
                    checkOutput("flagsB", {ovfB, inxB}, {eB.ovf[1:0], eB.inx[1:0]});
                    checkOutput("dataC", outC, eC.data);
                    checkOutput("flagsC", {ovfC, inxC}, {eC.ovf[1:0], eC.inx[1:0]});
                end
            end
            stallSeen = validA && !outReady;
            heldA = outA; heldB = outB; heldC = outC;
            if (inValid && readyA) begin
                qA.push_back(modelA(inA));
                qB.push_back(modelW16(inB, 1'b0));
                qC.push_back(modelW16(inC, 1'b1));
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Valid"}, {validA, validB, validC}, 3'b000);
        checkOutput({tag, "DataA"}, outA, 64'd0);
        checkOutput({tag, "DataBC"}, {outB, outC}, 64'd0);
        checkOutput({tag, "Flags"}, {ovfA, inxA, ovfB, inxB, ovfC, inxC}, 16'd0);
    endtask

    bit fire;

    initial begin
        reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
        inA = '0; inB = '0; inC = '0;
        tick(); tick();
        checkResetState("reset");
        reset = 1'b0;

        // Beat presented in cycle c is valid at the output in cycle c+2.
        applyStimulus(16'h8F10, {16'd2051, 16'd2049}, {16'h7FFF, 16'h8000});
        checkOutput("latencyEarly", validA, 0);
        tick();
        checkOutput("latencyValid", validA, 1);
        checkOutput("dirA", outA, 64'hC800_BC00_3C00_0000);
        checkOutput("dirFlagsA", {ovfA, inxA}, 8'h00);
        checkOutput("dirB", outB, 32'h6802_6800);
        checkOutput("dirFlagsB", {ovfB, inxB}, 4'b0011);
        checkOutput("dirC", outC, 32'h7800_F800);
        checkOutput("dirFlagsC", {ovfC, inxC}, 4'b0010);

        applyStimulus(16'h7080, {16'd65535, 16'd65519}, {16'hFFFF, 16'h0001});
        tick();
        checkOutput("ovfB", outB, {OVF_RESULT, 16'h7BFF});
        checkOutput("ovfFlagsB", {ovfB, inxB}, 4'b1011);

        // Backpressure: two beats fill the pipe, the third waits out the stall.
        randBeat(); applyStimulus(inA, inB, inC);
        outReady = 1'b0;
        randBeat(); applyStimulus(inA, inB, inC);
        randBeat();
        inValid = 1'b1;
        checkOutput("bpReadyFull", readyA, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("bpReadyHeld", readyA, 0);
        end
        outReady = 1'b1;
        applyStimulus(inA, inB, inC);
        for (int i = 0; i < 3; i++) begin
            randBeat(); applyStimulus(inA, inB, inC);
        end
        repeat (4) tick();
        checkOutput("bpDrained", qA.size(), 0);

        // Reset with both stages occupied.
        outReady = 1'b0;
        randBeat(); applyStimulus(inA, inB, inC);
        randBeat(); applyStimulus(inA, inB, inC);
        reset = 1'b1;
        tick();
        checkResetState("midReset");
        reset = 1'b0;
        outReady = 1'b1;
        randBeat(); applyStimulus(inA, inB, inC);
        checkOutput("postRstEarly", validA, 0);
        tick();
        checkOutput("postRstValid", validA, 1);
        tick();

        // Random traffic with random downstream stalls.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            fire = inValid && readyA;
            tick();
            if (fire || !inValid) begin
                inValid = ($urandom_range(0, 3) != 0);
                if (inValid) randBeat();
            end
            outReady = ($urandom_range(0, 3) != 0);
        end
        outReady = 1'b1;
        if (inValid) applyStimulus(inA, inB, inC);
        inValid = 1'b0;
        for (int i = 0; i < 20 && qA.size() != 0; i++) tick();
        checkOutput("finalDrain", qA.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
